mul_seq: RTL and testbench



---
 rtl/mul_seq.sv | 107 ++++++++++
 tb/tb_mul_seq.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/mul_seq.sv
// Sequential radix-2 shift-add multiplier giving a 2*DSZ-bit signed or unsigned product.
// Latency: done on the DSZ+2-th edge counting the start edge; with MUL_EARLY_EXIT_EN it is |y| MSB index + 3 (2 when |y|==0).
// Backpressure: start is taken only in IDLE (bsy low), so a start while busy is dropped; p holds until the next FIX.
module mul_seq #(
    parameter int DSZ = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sgn,
    input  logic [DSZ-1:0]   x,
    input  logic [DSZ-1:0]   y,
    output logic             bsy,
    output logic             done,
    output logic [2*DSZ-1:0] p
);
    localparam int CW = $clog2(DSZ);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state, state_nxt;
    logic [2*DSZ-1:0] acc, mc, acc_add;
    logic [DSZ-1:0]   mp, mp_sh, x_mag, y_mag;
    logic             neg;
    logic [CW-1:0]    cnt;

    // Operands become magnitudes in signed mode; -2^(DSZ-1) maps to 2^(DSZ-1), which fits unsigned.
    assign x_mag   = (sgn && x[DSZ-1]) ? -x : x;
    assign y_mag   = (sgn && y[DSZ-1]) ? -y : y;
    assign acc_add = acc + (mp[0] ? mc : '0);
    assign mp_sh   = mp >> 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
`ifdef MUL_EARLY_EXIT_EN
                    state_nxt = (y_mag == '0) ? FIX : RUN;
`else
                    state_nxt = RUN;
`endif
                end
            end
            RUN: begin
                if (cnt == '0) begin
                    state_nxt = FIX;
                end
`ifdef MUL_EARLY_EXIT_EN
                // No multiplier bits left means every remaining step would add zero.
                else if (mp_sh == '0) begin
                    state_nxt = FIX;
                end
`endif
            end
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            mc   <= '0;
            mp   <= '0;
            neg  <= 1'b0;
            cnt  <= '0;
            bsy  <= 1'b0;
            done <= 1'b0;
            p    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mc  <= {{DSZ{1'b0}}, x_mag};
                        mp  <= y_mag;
                        neg <= sgn & (x[DSZ-1] ^ y[DSZ-1]);
                        acc <= '0;
                        cnt <= CW'(DSZ - 1);
                        bsy <= 1'b1;
                    end
                end
                RUN: begin
                    acc <= acc_add;
                    mc  <= mc << 1;
                    mp  <= mp_sh;
                    cnt <= cnt - 1'b1;
                end
                FIX: begin
                    p    <= neg ? -acc : acc;
                    bsy  <= 1'b0;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_seq.sv
// Directed-vector bench for mul_seq: product, latency, busy window, done pulse width, reset and back-to-back starts.
module tb_mul_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sgn = 1'b0;
    logic [31:0] x = '0;
    logic [31:0] y = '0;
    logic        bsy;
    logic        done;
    logic [63:0] p;

    int n_cmp = 0;
    int n_bad = 0;

    mul_seq #(.DSZ(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sgn(sgn),
        .x(x), .y(y), .bsy(bsy), .done(done), .p(p)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Edges from the start edge to done, as the build is expected to behave.
    function automatic int exp_lat(input logic [31:0] b, input logic s);
        logic [31:0] m;
        int hi;
        m  = (s && b[31]) ? -b : b;
        hi = -1;
        for (int i = 0; i < 32; i++) if (m[i]) hi = i;
`ifdef MUL_EARLY_EXIT_EN
        return (hi < 0) ? 2 : hi + 3;
`else
        return 34;
`endif
    endfunction

    task automatic mul_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [63:0] ep);
        int n;
        int nb;
        int lat;
        lat = exp_lat(b, s);
        nb  = 0;
        @(negedge clk);
        x = a; y = b; sgn = s; start = 1'b1;
        @(posedge clk); #1;
        n = 1;
        start = 1'b0;
        x = ~a; y = ~b; sgn = ~s;
        if (bsy) nb++;
        while (!done && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (bsy) nb++;
        end
        chk({tag, " latency"}, 64'(n), 64'(lat));
        chk({tag, " product"}, p, ep);
        chk({tag, " bsy cycles"}, 64'(nb), 64'(lat - 1));
        @(posedge clk); #1;
        chk({tag, " done width"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        int nd;
        int first;
        int last;
        int lat;

        #22;
        chk("reset bsy", {63'd0, bsy}, 64'd0);
        chk("reset done", {63'd0, done}, 64'd0);
        chk("reset p", p, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        mul_op("u max*max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
        mul_op("s -7*6", 32'hFFFF_FFF9, 32'd6, 1'b1, 64'hFFFF_FFFF_FFFF_FFD6);
        mul_op("u -7*6", 32'hFFFF_FFF9, 32'd6, 1'b0, 64'h0000_0005_FFFF_FFD6);
        mul_op("s 6*-7", 32'd6, 32'hFFFF_FFF9, 1'b1, 64'hFFFF_FFFF_FFFF_FFD6);
        mul_op("s min*min", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
        mul_op("s min*1", 32'h8000_0000, 32'd1, 1'b1, 64'hFFFF_FFFF_8000_0000);
        mul_op("u 100*1", 32'd100, 32'd1, 1'b0, 64'd100);
        mul_op("u 100*0", 32'd100, 32'd0, 1'b0, 64'd0);
        mul_op("u 3*2^31", 32'd3, 32'h8000_0000, 1'b0, 64'h0000_0001_8000_0000);
        mul_op("s 0*5", 32'd0, 32'd5, 1'b1, 64'd0);

        // start held high: one result per latency period, accepted in each done cycle
        lat   = exp_lat(32'd5, 1'b0);
        nd    = 0;
        first = 0;
        last  = 0;
        @(negedge clk);
        x = 32'd3; y = 32'd5; sgn = 1'b0; start = 1'b1;
        for (int e = 1; e <= 3 * lat + 2; e++) begin
            @(posedge clk); #1;
            if (done) begin
                nd++;
                if (first == 0) first = e;
                last = e;
                chk("stream product", p, 64'd15);
            end
        end
        start = 1'b0;
        chk("stream done count", 64'(nd), 64'd3);
        chk("stream first done", 64'(first), 64'(lat));
        chk("stream last done", 64'(last), 64'(3 * lat));
        repeat (40) @(posedge clk);
        #1;

        // reset asserted after edge 10 of an operation
        @(negedge clk);
        x = 32'd12345; y = 32'd678; sgn = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midreset bsy", {63'd0, bsy}, 64'd0);
        chk("midreset done", {63'd0, done}, 64'd0);
        chk("midreset p", p, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int e = 0; e < 40; e++) begin
            @(posedge clk); #1;
            if (done || bsy) nd++;
        end
        chk("no stale activity", 64'(nd), 64'd0);
        mul_op("u 12345*678", 32'd12345, 32'd678, 1'b0, 64'd8369910);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
